// File: rtl/frog_move_if.sv
// Button/vsync inputs and frog position outputs exchanged between the
// player-input block and the VGA-side logic.
interface frog_move_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       vsync;
  logic [9:0] frog_x;
  logic [9:0] frog_y;
  logic       moved;
  logic       bumped;
  logic       busy;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, vsync,
    input  frog_x, frog_y, moved, bumped, busy
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, vsync,
    output frog_x, frog_y, moved, bumped, busy
  );
endinterface

// File: rtl/frog_move_ctrl.sv
// Debounced four-button frog controller: queues one grid move, commits it at
// vsync rise, clamps to the playfield and enforces a frame-based cooldown.
module frog_move_ctrl #(
  parameter int GRID_SIZE       = 32,
  parameter int H_CELLS         = 20,
  parameter int V_CELLS         = 15,
  parameter int START_COL       = 10,
  parameter int START_ROW       = 14,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int COOLDOWN_FRAMES = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  frog_move_if.slave  bus
);

  localparam int SHIFT = $clog2(GRID_SIZE);
  localparam int COL_W = $clog2(H_CELLS);
  localparam int ROW_W = $clog2(V_CELLS);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int CD_W  = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

  localparam logic [CNT_W-1:0] DEB_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [COL_W-1:0] COL_MAX   = COL_W'(H_CELLS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(V_CELLS - 1);
  localparam logic [COL_W-1:0] COL_START = COL_W'(START_COL);
  localparam logic [ROW_W-1:0] ROW_START = ROW_W'(START_ROW);
  localparam logic [CD_W-1:0]  CD_LOAD   = CD_W'(COOLDOWN_FRAMES);

  typedef enum logic [1:0] {IDLE, PENDING, APPLY, COOLDOWN} state_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  logic [3:0]       btn_raw;
  logic [3:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [3:0]       deb_q, deb_d, deb_prev_q, deb_prev_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       press;
  logic             vsync_q, vsync_d, vs_rise;

  state_t           state_q, state_d;
  dir_t             dir_q, dir_d;
  logic [CD_W-1:0]  cd_q, cd_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             moved_q, moved_d, bumped_q, bumped_d;

  assign btn_raw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

  // The counter only advances while the synchronised input disagrees with the
  // accepted level, so any bounce back to the old level restarts the wait.
  always_comb begin
    sync1_d    = btn_raw;
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    vsync_d    = bus.vsync;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DEB_MAX) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  assign press   = deb_q & ~deb_prev_q;
  assign vs_rise = bus.vsync & ~vsync_q;

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    cd_d     = cd_q;
    col_d    = col_q;
    row_d    = row_q;
    moved_d  = 1'b0;
    bumped_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|press) begin
          state_d = PENDING;
          if (press[0])      dir_d = DIR_UP;
          else if (press[1]) dir_d = DIR_DOWN;
          else if (press[2]) dir_d = DIR_LEFT;
          else               dir_d = DIR_RIGHT;
        end
      end
      PENDING: begin
        if (vs_rise) state_d = APPLY;
      end
      APPLY: begin
        case (dir_q)
          DIR_UP: begin
            if (row_q == '0) bumped_d = 1'b1;
            else begin row_d = row_q - 1'b1; moved_d = 1'b1; end
          end
          DIR_DOWN: begin
            if (row_q == ROW_MAX) bumped_d = 1'b1;
            else begin row_d = row_q + 1'b1; moved_d = 1'b1; end
          end
          DIR_LEFT: begin
            if (col_q == '0) bumped_d = 1'b1;
            else begin col_d = col_q - 1'b1; moved_d = 1'b1; end
          end
          default: begin
            if (col_q == COL_MAX) bumped_d = 1'b1;
            else begin col_d = col_q + 1'b1; moved_d = 1'b1; end
          end
        endcase
        cd_d    = CD_LOAD;
        state_d = COOLDOWN;
      end
      COOLDOWN: begin
        if (cd_q == '0) begin
          state_d = IDLE;
        end else if (vs_rise) begin
          cd_d = cd_q - 1'b1;
          if (cd_q == CD_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      vsync_q    <= 1'b0;
      state_q    <= IDLE;
      dir_q      <= DIR_UP;
      cd_q       <= '0;
      col_q      <= COL_START;
      row_q      <= ROW_START;
      moved_q    <= 1'b0;
      bumped_q   <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      vsync_q    <= vsync_d;
      state_q    <= state_d;
      dir_q      <= dir_d;
      cd_q       <= cd_d;
      col_q      <= col_d;
      row_q      <= row_d;
      moved_q    <= moved_d;
      bumped_q   <= bumped_d;
    end
  end

  assign bus.frog_x = 10'(col_q) << SHIFT;
  assign bus.frog_y = 10'(row_q) << SHIFT;
  assign bus.moved  = moved_q;
  assign bus.bumped = bumped_q;
  assign bus.busy   = (state_q != IDLE);

endmodule

// File: tb/tb_frog_move_ctrl.sv
// Self-checking bench for frog_move_ctrl: vector table, directed corner
// sequences and randomized presses against a grid-level reference model.
module tb_frog_move_ctrl;
  localparam int GRID = 32;
  localparam int HC   = 20;
  localparam int VC   = 15;

  logic clk;
  logic rst_n;
  frog_move_if bus ();

  frog_move_ctrl #(
    .GRID_SIZE(GRID), .H_CELLS(HC), .V_CELLS(VC),
    .START_COL(10), .START_ROW(14),
    .DEBOUNCE_CYCLES(4), .COOLDOWN_FRAMES(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_moved = 0;
  int n_bumped = 0;

  always @(negedge clk) begin
    if (bus.moved)  n_moved++;
    if (bus.bumped) n_bumped++;
  end

  typedef struct {
    logic [3:0] mask;  // [0]=up [1]=down [2]=left [3]=right
    int exp_moved;
    int exp_bumped;
    int exp_x;
    int exp_y;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input logic [3:0] m);
    bus.btn_up    = m[0];
    bus.btn_down  = m[1];
    bus.btn_left  = m[2];
    bus.btn_right = m[3];
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic do_press(input logic [3:0] m, input int hold);
    set_btn(m);
    tick(hold);
    set_btn(4'b0000);
    tick(12);
  endtask

  task automatic frame();
    bus.vsync = 1'b1;
    tick(3);
    bus.vsync = 1'b0;
    tick(3);
  endtask

  // Press, one frame to commit, two frames of cooldown.
  task automatic do_move(input logic [3:0] m, output int mv, output int bp);
    int m0, b0;
    m0 = n_moved;
    b0 = n_bumped;
    do_press(m, 10);
    frame();
    frame();
    frame();
    mv = n_moved - m0;
    bp = n_bumped - b0;
  endtask

  int mv, bp, m0, b0;
  int mcol, mrow, tcol, trow, e_mv, e_bp;
  logic [3:0] m;
  int hold;
  bit glitch;

  initial begin
    vecs[0] = '{4'b0010, 0, 1, 320, 448};  // down from bottom row
    vecs[1] = '{4'b0001, 1, 0, 320, 416};  // up
    vecs[2] = '{4'b1100, 1, 0, 288, 416};  // left beats right
    vecs[3] = '{4'b1000, 1, 0, 320, 416};  // right
    vecs[4] = '{4'b1111, 1, 0, 320, 384};  // up beats all
    vecs[5] = '{4'b0110, 1, 0, 320, 416};  // down beats left

    rst_n = 1'b0;
    bus.vsync = 1'b0;
    set_btn(4'b0000);
    tick(3);
    rst_n = 1'b1;
    tick(2);

    check("reset_x", bus.frog_x, 320);
    check("reset_y", bus.frog_y, 448);
    check("reset_busy", bus.busy, 0);
    check("reset_moved", bus.moved, 0);
    check("reset_bumped", bus.bumped, 0);

    // Reset while a move is pending drops it.
    do_press(4'b0001, 10);
    check("pending_busy", bus.busy, 1);
    do_reset();
    check("pending_rst_busy", bus.busy, 0);
    m0 = n_moved;
    frame();
    frame();
    check("pending_rst_nomove", n_moved - m0, 0);
    check("pending_rst_y", bus.frog_y, 448);

    // Commit latency: position changes two cycles after vsync rise.
    do_press(4'b0001, 10);
    bus.vsync = 1'b1;
    tick(1);
    check("lat_y_apply", bus.frog_y, 448);
    check("lat_moved_apply", bus.moved, 0);
    tick(1);
    check("lat_y_commit", bus.frog_y, 416);
    check("lat_moved_commit", bus.moved, 1);
    check("lat_x_commit", bus.frog_x, 320);
    tick(1);
    check("lat_moved_clear", bus.moved, 0);
    tick(2);
    bus.vsync = 1'b0;
    tick(3);
    frame();
    frame();
    check("lat_idle", bus.busy, 0);

    // Vector table from the reset position.
    do_reset();
    foreach (vecs[i]) begin
      do_move(vecs[i].mask, mv, bp);
      check($sformatf("vec%0d_moved", i), mv, vecs[i].exp_moved);
      check($sformatf("vec%0d_bumped", i), bp, vecs[i].exp_bumped);
      check($sformatf("vec%0d_x", i), bus.frog_x, vecs[i].exp_x);
      check($sformatf("vec%0d_y", i), bus.frog_y, vecs[i].exp_y);
      check($sformatf("vec%0d_idle", i), bus.busy, 0);
    end

    // Re-press during cooldown is dropped.
    do_reset();
    m0 = n_moved;
    do_press(4'b1000, 10);
    frame();
    do_press(4'b1000, 10);
    check("cd_busy", bus.busy, 1);
    frame();
    frame();
    check("cd_idle", bus.busy, 0);
    check("cd_single_move", n_moved - m0, 1);
    check("cd_x", bus.frog_x, 352);
    frame();
    check("cd_no_late_move", n_moved - m0, 1);
    do_move(4'b1000, mv, bp);
    check("cd_after_x", bus.frog_x, 384);

    // Short glitch never becomes a press.
    do_reset();
    do_press(4'b0001, 2);
    check("glitch_busy", bus.busy, 0);
    frame();
    check("glitch_y", bus.frog_y, 448);

    // Left and right playfield edges.
    do_reset();
    for (int i = 0; i < 10; i++) do_move(4'b0100, mv, bp);
    check("left_edge_x", bus.frog_x, 0);
    do_move(4'b0100, mv, bp);
    check("left_bump", bp, 1);
    check("left_bump_nomove", mv, 0);
    check("left_bump_x", bus.frog_x, 0);
    for (int i = 0; i < 19; i++) do_move(4'b1000, mv, bp);
    check("right_edge_x", bus.frog_x, 608);
    do_move(4'b1000, mv, bp);
    check("right_bump", bp, 1);
    check("right_bump_x", bus.frog_x, 608);

    // Randomized presses and glitches against a grid model.
    do_reset();
    mcol = 10;
    mrow = 14;
    for (int it = 0; it < 60; it++) begin
      glitch = ($urandom_range(0, 4) == 0);
      m = 4'($urandom_range(1, 15));
      hold = glitch ? $urandom_range(1, 2) : $urandom_range(6, 12);
      e_mv = 0;
      e_bp = 0;
      if (!glitch) begin
        tcol = mcol;
        trow = mrow;
        if (m[0])      trow = mrow - 1;
        else if (m[1]) trow = mrow + 1;
        else if (m[2]) tcol = mcol - 1;
        else           tcol = mcol + 1;
        if (tcol < 0 || tcol >= HC || trow < 0 || trow >= VC) e_bp = 1;
        else begin
          e_mv = 1;
          mcol = tcol;
          mrow = trow;
        end
      end
      m0 = n_moved;
      b0 = n_bumped;
      do_press(m, hold);
      check($sformatf("rnd%0d_busy", it), bus.busy, glitch ? 0 : 1);
      frame();
      frame();
      frame();
      check($sformatf("rnd%0d_moved", it), n_moved - m0, e_mv);
      check($sformatf("rnd%0d_bumped", it), n_bumped - b0, e_bp);
      check($sformatf("rnd%0d_x", it), bus.frog_x, mcol * GRID);
      check($sformatf("rnd%0d_y", it), bus.frog_y, mrow * GRID);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
